preg_free_list: RTL

Physical-register free-list manager for the out-of-order core. It owns the pool of 64 physical registers and arbitrates it between rename, which allocates one destination per cycle, and retire, which returns one stale mapping per cycle. It replaces ad-hoc scanning of the busy column with a circular FIFO plus a busy bitmap. After reset it self-initialises over a fixed number of cycles.

---
 rtl/preg_free_list_pkg.sv | 21 ++
 rtl/preg_fifo.sv | 49 ++++
 rtl/preg_free_list.sv | 116 +++++++++++
 3 files changed

// File: rtl/preg_free_list_pkg.sv
// Shared constants and types for the physical-register free list.
// Tag width is derived from the pool size.
package preg_free_list_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW = $clog2(NUM_PREGS);

  typedef logic [PW-1:0] preg_t;
  typedef logic [PW:0] cnt_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Architectural regs p0..p(NUM_AREGS-1) hold mappings out of reset.
  localparam logic [NUM_PREGS-1:0] BUSY_RST =
    {{(NUM_PREGS-NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};

endpackage

// File: rtl/preg_fifo.sv
// Circular tag store with one write and one read port.
// Occupancy is tracked by count, not by pointer equality.
module preg_fifo
  import preg_free_list_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_data,
  input  logic          rd_en,
  output logic [PW-1:0] rd_data,
  output logic [PW:0]   count
);

  preg_t mem [NUM_PREGS];
  preg_t head;
  preg_t tail;

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointers wrap naturally at PW bits; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        tail <= tail + 1'b1;
      end
      if (rd_en) begin
        head <= head + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: init sequencer, busy bitmap,
// allocate/free arbitration and sticky illegal-free flag.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_gnt,
  output logic [PW-1:0] alloc_preg,
  input  logic          free_valid,
  input  logic [PW-1:0] free_preg,
  output logic [PW:0]   free_count,
  output logic          init_done,
  output logic          err
);

  state_t state;
  state_t state_nxt;
  preg_t  init_ptr;
  logic [NUM_PREGS-1:0] busy;

  logic  in_init;
  logic  in_run;
  logic  free_ok;
  logic  free_bad;
  logic  wr_en;
  preg_t wr_data;
  preg_t head_tag;
  cnt_t  count;

  assign in_init = (state == INIT);
  assign in_run  = (state == RUN);

  // INIT seeds the list once per cycle; RUN is left only by reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: begin
        if (init_ptr == PW'(NUM_PREGS-1)) begin
          state_nxt = RUN;
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next tag to seed during INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr <= PW'(NUM_AREGS);
    end else if (in_init) begin
      init_ptr <= init_ptr + 1'b1;
    end
  end

  // Reset overrides a grant in the same cycle.
  assign alloc_gnt = !rst && in_run && alloc_req
                     && (count != '0);
  assign alloc_preg = alloc_gnt ? head_tag : '0;

  // A tag in the list is never busy, so a double free is caught here.
  assign free_ok  = in_run && free_valid
                    && (free_preg != '0) && busy[free_preg];
  assign free_bad = free_valid && !free_ok;

  assign wr_en   = in_init || free_ok;
  assign wr_data = in_init ? init_ptr : free_preg;

  preg_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (alloc_gnt),
    .rd_data (head_tag),
    .count   (count)
  );

  // Busy bitmap: set on grant, cleared on accepted free.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= BUSY_RST;
    end else begin
      if (alloc_gnt) begin
        busy[head_tag] <= 1'b1;
      end
      if (free_ok) begin
        busy[free_preg] <= 1'b0;
      end
    end
  end

  // Sticky illegal-free flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (free_bad) begin
      err <= 1'b1;
    end
  end

  assign free_count = count;
  assign init_done  = in_run;

endmodule
